// File: rtl/prog_minterm_pkg.sv
// rtl/prog_minterm_pkg.sv - shared types and width helpers for prog_minterm_lut
// Contents:
//   sweep_state_e : sweep controller states
//   tt_width      : truth-table width for a given input count (2**n_in)
//   cnt_width     : per-channel minterm count width (n_in+1, holds 2**n_in)
//   ch_offset     : bit offset of channel k in the packed count bus
package prog_minterm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int cnt_width(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int ch_offset(input int k, input int cw);
        return k * cw;
    endfunction

endpackage

// File: rtl/minterm_table.sv
// rtl/minterm_table.sv - CH x TT_W truth-table register file with two read ports
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset (clears every table)
//   we_i           : write strobe
//   wr_ch_i        : channel to write; codes >= CH match no row and are dropped
//   wr_word_i      : new truth table for wr_ch_i
//   eval_idx_i     : input-vector index for the evaluation read port
//   eval_bits_o    : bit k = table[k][eval_idx_i]
//   sweep_idx_i    : index for the sweep read port
//   sweep_bits_o   : bit k = table[k][sweep_idx_i]
module minterm_table #(
    parameter int N_IN = 4,
    parameter int CH   = 2,
    parameter int TT_W = 16,
    parameter int CHW  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [CHW-1:0]    wr_ch_i,
    input  logic [TT_W-1:0]   wr_word_i,
    input  logic [N_IN-1:0]   eval_idx_i,
    output logic [CH-1:0]     eval_bits_o,
    input  logic [N_IN-1:0]   sweep_idx_i,
    output logic [CH-1:0]     sweep_bits_o
);

    logic [TT_W-1:0] tbl_q [CH];

    for (genvar k = 0; k < CH; k++) begin : g_ch
        // Only codes 0..CH-1 can match a row, so out-of-range channels write nothing.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                tbl_q[k] <= '0;
            end else if (we_i && (wr_ch_i == CHW'(k))) begin
                tbl_q[k] <= wr_word_i;
            end
        end

        // Reads are combinational from the registered table, so a same-cycle
        // write is seen only by reads in later cycles.
        assign eval_bits_o[k]  = tbl_q[k][eval_idx_i];
        assign sweep_bits_o[k] = tbl_q[k][sweep_idx_i];
    end

endmodule

// File: rtl/prog_minterm_lut.sv
// rtl/prog_minterm_lut.sv - programmable multi-channel sum-of-minterms evaluator
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   cfg_valid/cfg_ready/cfg_ch/cfg_word : truth-table load (bit i = output for index i)
//   in_valid/in_ready/in_vec        : input vector to evaluate (in_vec MSB is "A")
//   out_valid/out_ready/out_y       : registered result, bit k = channel k
//   sweep_start                     : single-cycle request to count minterms
//   sweep_busy/sweep_done           : sweep in progress / counts final (one cycle)
//   minterm_count                   : channel k count at [k*CW +: CW]
module prog_minterm_lut
    import prog_minterm_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int CH   = 2,
    parameter int TT_W = tt_width(N_IN),
    parameter int CW   = cnt_width(N_IN),
    parameter int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [TT_W-1:0]   cfg_word,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH-1:0]     out_y,
    input  logic              sweep_start,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic [CH*CW-1:0]  minterm_count
);

    sweep_state_e      state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [CH*CW-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [CH-1:0]     out_y_q, out_y_d;

    logic [CH-1:0]     eval_bits;
    logic [CH-1:0]     sweep_bits;
    logic              idle;
    logic              cfg_fire;
    logic              in_fire;

    // A sweep request takes priority over config and evaluation in the same cycle.
    assign idle      = (state_q == IDLE);
    assign cfg_ready = idle && !sweep_start;
    assign in_ready  = cfg_ready && (!out_valid_q || out_ready);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign in_fire   = in_valid && in_ready;

    minterm_table #(
        .N_IN (N_IN),
        .CH   (CH),
        .TT_W (TT_W),
        .CHW  (CHW)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .we_i         (cfg_fire),
        .wr_ch_i      (cfg_ch),
        .wr_word_i    (cfg_word),
        .eval_idx_i   (in_vec),
        .eval_bits_o  (eval_bits),
        .sweep_idx_i  (idx_q),
        .sweep_bits_o (sweep_bits)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
        end
    end

    // Next-state logic for the sweep controller and its counters
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                for (int k = 0; k < CH; k++) begin
                    cnt_d[ch_offset(k, CW) +: CW] =
                        cnt_q[ch_offset(k, CW) +: CW] + CW'(sweep_bits[k]);
                end
                // All-ones index is the last table entry.
                if (&idx_q) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + N_IN'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic for the sweep controller
    always_comb begin
        sweep_busy = (state_q != IDLE);
        sweep_done = (state_q == DONE);
    end

    // Result register: independent of the sweep so a pending result can drain
    // while the sweep runs.
    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_y_d     = eval_bits;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_y         = out_y_q;
    assign minterm_count = cnt_q;

endmodule

// File: tb/tb_prog_minterm_lut.sv
// tb/tb_prog_minterm_lut.sv - self-checking bench for prog_minterm_lut
module tb_prog_minterm_lut;

    localparam int N_IN = 4;
    localparam int CH   = 2;
    localparam int TT_W = 16;
    localparam int CW   = 5;
    localparam int CHW  = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHW-1:0]    cfg_ch;
    logic [TT_W-1:0]   cfg_word;
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_vec;
    logic              out_valid;
    logic              out_ready;
    logic [CH-1:0]     out_y;
    logic              sweep_start;
    logic              sweep_busy;
    logic              sweep_done;
    logic [CH*CW-1:0]  minterm_count;

    always #5 clk = ~clk;

    prog_minterm_lut #(
        .N_IN (N_IN),
        .CH   (CH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_ch        (cfg_ch),
        .cfg_word      (cfg_word),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_vec        (in_vec),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_y         (out_y),
        .sweep_start   (sweep_start),
        .sweep_busy    (sweep_busy),
        .sweep_done    (sweep_done),
        .minterm_count (minterm_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: tables, sweep position (0 idle, 1..TT_W sweeping, TT_W+1 done)
    logic [TT_W-1:0] m_tbl [CH];
    int              m_cyc;
    logic            m_ov;
    logic [CH-1:0]   m_oy;
    int              m_cnt [CH];
    bit              m_init = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Count visible in sweep cycle n covers indices 0..n-2.
    function automatic int exp_cnt(input int k);
        int s;
        s = 0;
        if (m_cyc == 0) return m_cnt[k];
        for (int i = 0; i < m_cyc - 1; i++) s += int'(m_tbl[k][i]);
        return s;
    endfunction

    task automatic step(input logic rst, input logic cv, input logic [CHW-1:0] cch,
                        input logic [TT_W-1:0] cw, input logic iv, input logic [N_IN-1:0] ivec,
                        input logic ordy, input logic sst);
        logic idle;
        logic e_cfg_rdy;
        logic e_in_rdy;
        rst_n       = !rst;
        cfg_valid   = cv;
        cfg_ch      = cch;
        cfg_word    = cw;
        in_valid    = iv;
        in_vec      = ivec;
        out_ready   = ordy;
        sweep_start = sst;
        #2;
        idle      = (m_cyc == 0);
        e_cfg_rdy = idle && !sst;
        e_in_rdy  = e_cfg_rdy && (!m_ov || ordy);
        if (m_init) begin
            chk("cfg_ready", 32'(cfg_ready), 32'(e_cfg_rdy));
            chk("in_ready", 32'(in_ready), 32'(e_in_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("out_y", 32'(out_y), 32'(m_oy));
            chk("sweep_busy", 32'(sweep_busy), 32'(m_cyc != 0));
            chk("sweep_done", 32'(sweep_done), 32'(m_cyc == TT_W + 1));
            for (int k = 0; k < CH; k++)
                chk($sformatf("count%0d", k), 32'(minterm_count[k*CW +: CW]), 32'(exp_cnt(k)));
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                m_tbl[k] = '0;
                m_cnt[k] = 0;
            end
            m_cyc  = 0;
            m_ov   = 1'b0;
            m_oy   = '0;
            m_init = 1'b1;
        end else begin
            if (iv && e_in_rdy) begin
                m_ov = 1'b1;
                for (int k = 0; k < CH; k++) m_oy[k] = m_tbl[k][ivec];
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            if (cv && e_cfg_rdy && int'(cch) < CH) m_tbl[cch] = cw;
            if (idle && sst) begin
                m_cyc = 1;
            end else if (m_cyc == TT_W + 1) begin
                for (int k = 0; k < CH; k++) m_cnt[k] = $countones(m_tbl[k]);
                m_cyc = 0;
            end else if (m_cyc != 0) begin
                m_cyc++;
            end
        end
        #1;
    endtask

    task automatic idle_step(input logic ordy);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, ordy, 1'b0);
    endtask

    task automatic eval_step(input logic [N_IN-1:0] v, input logic ordy);
        step(1'b0, 1'b0, '0, '0, 1'b1, v, ordy, 1'b0);
    endtask

    typedef struct {
        logic            rst;
        logic            cv;
        logic [CHW-1:0]  cch;
        logic [TT_W-1:0] cw;
        logic            iv;
        logic [N_IN-1:0] ivec;
        logic            chk_y;
        logic [CH-1:0]   exp_y;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic cv, input logic [CHW-1:0] cch,
                                input logic [TT_W-1:0] cw, input logic iv,
                                input logic [N_IN-1:0] ivec, input logic cy, input logic [CH-1:0] ey);
        vec_t v;
        v.rst = rst; v.cv = cv; v.cch = cch; v.cw = cw;
        v.iv = iv; v.ivec = ivec; v.chk_y = cy; v.exp_y = ey;
        return v;
    endfunction

    int busy_n;
    int done_at;

    initial begin
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 4'h0, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4'hF, 1, 2'b00));
        vecs.push_back(mk(0, 1, 0, 16'h545E, 0, 4'h0, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4'h6, 1, 2'b01));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4'h5, 1, 2'b00));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4'h1, 1, 2'b01));
        vecs.push_back(mk(0, 1, 1, 16'hFFFF, 0, 4'h0, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4'h3, 1, 2'b11));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4'h0, 1, 2'b10));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 4'h0, 0, 2'b00));
        vecs.push_back(mk(0, 1, 0, 16'hFFFF, 1, 4'h3, 1, 2'b00));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4'h3, 1, 2'b01));
        vecs.push_back(mk(0, 1, 1, 16'h00F0, 1, 4'h4, 1, 2'b01));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 4'h4, 1, 2'b11));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].cv, vecs[i].cch, vecs[i].cw,
                 vecs[i].iv, vecs[i].ivec, 1'b1, 1'b0);
            if (vecs[i].chk_y) begin
                chk($sformatf("vec%0d_y", i), 32'(out_y), 32'(vecs[i].exp_y));
                chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            end
        end

        // Sweep: sweep_start with cfg and eval in the same cycle; the sweep wins.
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        chk("reset_count", 32'(minterm_count), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h545E, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 4'h6, 1'b1, 1'b1);
        busy_n  = 0;
        done_at = 0;
        for (int c = 1; c <= 24; c++) begin
            if (sweep_busy === 1'b1) busy_n++;
            if (sweep_done === 1'b1 && done_at == 0) done_at = c;
            idle_step(1'b1);
        end
        chk("sweep_busy_cycles", 32'(busy_n), 32'd17);
        chk("sweep_done_cycle", 32'(done_at), 32'd17);
        chk("sweep_counts", 32'(minterm_count), 32'(10'b10000_01000));
        eval_step(4'h6, 1'b1);
        chk("table_kept_after_sweep_start", 32'(out_y), 32'(2'b11));

        // Back-pressure: first result held, second accepted only once out_ready=1.
        idle_step(1'b1);
        eval_step(4'h6, 1'b0);
        chk("bp_first", 32'(out_y), 32'(2'b11));
        eval_step(4'h5, 1'b0);
        chk("bp_hold1", 32'(out_y), 32'(2'b11));
        chk("bp_valid1", 32'(out_valid), 32'd1);
        eval_step(4'h5, 1'b0);
        chk("bp_hold2", 32'(out_y), 32'(2'b11));
        eval_step(4'h5, 1'b1);
        chk("bp_second", 32'(out_y), 32'(2'b10));
        chk("bp_valid2", 32'(out_valid), 32'd1);
        idle_step(1'b1);

        // Reset in sweep cycle 5 aborts the sweep and clears tables and counts.
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        for (int c = 1; c <= 4; c++) idle_step(1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        chk("abort_busy", 32'(sweep_busy), 32'd0);
        chk("abort_count", 32'(minterm_count), 32'd0);
        eval_step(4'hF, 1'b1);
        chk("abort_tables", 32'(out_y), 32'(2'b00));
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        for (int c = 1; c <= 17; c++) idle_step(1'b1);
        chk("abort_resweep_count", 32'(minterm_count), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0,
                 CHW'($urandom_range(0, CH - 1)),
                 TT_W'($urandom),
                 $urandom_range(0, 1) == 1,
                 N_IN'($urandom),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
